// File: rtl/score_pkg.sv
// Shared constants and types for the score path (score keeper and score display).
package score_pkg;

  localparam int unsigned DIGIT_W         = 4;
  localparam int unsigned DEF_MAX_SCORE   = 999;
  localparam int unsigned DEF_DIGITS      = 3;
  localparam int unsigned DEF_SCORE_W     = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PLAYING = 2'd1,
    ST_OVER    = 2'd2
  } state_t;

endpackage

// File: rtl/score_keeper_if.sv
// Event/score bundle between game logic (master) and the score keeper (slave).
interface score_keeper_if
  import score_pkg::*;
#(
  parameter int unsigned SCORE_W = DEF_SCORE_W,
  parameter int unsigned DIGITS  = DEF_DIGITS
) ();

  logic                        game_start;
  logic                        point_event;
  logic                        game_over;
  logic                        frame_start;
  logic [SCORE_W-1:0]          score;
  logic [DIGIT_W*DIGITS-1:0]   score_bcd;
  logic [SCORE_W-1:0]          high_score;
  logic                        new_high;
  logic                        score_updated;
  logic [1:0]                  state;

  modport master (
    output game_start, point_event, game_over, frame_start,
    input  score, score_bcd, high_score, new_high, score_updated, state
  );

  modport slave (
    input  game_start, point_event, game_over, frame_start,
    output score, score_bcd, high_score, new_high, score_updated, state
  );

endinterface

// File: rtl/bcd_digit_counter.sv
// One BCD decade: counts 0..9 on inc, carries out when rolling over from 9.
module bcd_digit_counter
  import score_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               clr,
  input  logic               inc,
  input  logic               hold,
  output logic [DIGIT_W-1:0] digit,
  output logic               carry_out
);

  assign carry_out = inc && (digit == DIGIT_W'(9));

  // Decade register: clear has priority, hold freezes the value at saturation.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      digit <= '0;
    end else if (clr) begin
      digit <= '0;
    end else if (inc && !hold) begin
      digit <= carry_out ? '0 : digit + DIGIT_W'(1);
    end
  end

endmodule

// File: rtl/score_keeper.sv
// Score keeper: live binary/BCD score, round FSM, frame-stable shadow outputs.
// Optional feature macro: SCORE_HIGH_SCORE_EN (session high-score tracking).
module score_keeper
  import score_pkg::*;
#(
  parameter int unsigned MAX_SCORE = DEF_MAX_SCORE,
  parameter int unsigned DIGITS    = DEF_DIGITS,
  parameter int unsigned SCORE_W   = DEF_SCORE_W
) (
  input  logic           clk,
  input  logic           reset_n,
  score_keeper_if.slave  sif
);

  localparam int unsigned BCD_W = DIGIT_W * DIGITS;

  state_t             state_q, state_d;
  logic               clear;
  logic               round_end;
  logic               count_en;
  logic               sat;
  logic               bin_inc;
  logic [SCORE_W-1:0] live_bin;
  logic [BCD_W-1:0]   live_bcd;
  logic [DIGITS:0]    inc_chain;
  logic               chain_unused;
  logic [SCORE_W-1:0] score_q;
  logic [BCD_W-1:0]   bcd_q;
  logic               updated_q;
  logic               high_diff;
  logic [SCORE_W-1:0] high_cur;

  // Round FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next state: game_start wins over everything, game_over only ends a live round.
  always_comb begin
    state_d   = state_q;
    clear     = 1'b0;
    round_end = 1'b0;
    if (sif.game_start) begin
      state_d = ST_PLAYING;
      clear   = 1'b1;
    end else if (state_q == ST_PLAYING && sif.game_over) begin
      state_d   = ST_OVER;
      round_end = 1'b1;
    end
  end

  assign count_en = (state_q == ST_PLAYING) && sif.point_event && !sif.game_start;
  assign sat      = (live_bin == SCORE_W'(MAX_SCORE));
  assign bin_inc  = count_en && !sat;

  // Live binary counter, frozen at the saturation ceiling.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     live_bin <= '0;
    else if (clear)   live_bin <= '0;
    else if (bin_inc) live_bin <= live_bin + SCORE_W'(1);
  end

  assign inc_chain[0] = count_en;
  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_digit_counter u_digit (
      .clk       (clk),
      .reset_n   (reset_n),
      .clr       (clear),
      .inc       (inc_chain[i]),
      .hold      (sat),
      .digit     (live_bcd[i*DIGIT_W +: DIGIT_W]),
      .carry_out (inc_chain[i+1])
    );
  end
  // Carry out of the top decade only ever fires while held at saturation.
  assign chain_unused = inc_chain[DIGITS];

`ifdef SCORE_HIGH_SCORE_EN
  logic [SCORE_W-1:0] high_q;
  logic [SCORE_W-1:0] high_sh_q;
  logic               new_high_q;
  logic [SCORE_W-1:0] final_score;

  // A point arriving with game_over still counts toward the final score.
  assign final_score = bin_inc ? live_bin + SCORE_W'(1) : live_bin;

  // High-score register and new_high flag, evaluated at round end.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      high_q     <= '0;
      new_high_q <= 1'b0;
    end else if (sif.game_start) begin
      new_high_q <= 1'b0;
    end else if (round_end) begin
      if (final_score > high_q) begin
        high_q     <= final_score;
        new_high_q <= 1'b1;
      end else begin
        new_high_q <= 1'b0;
      end
    end
  end

  // Frame-stable copy of the high score.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)             high_sh_q <= '0;
    else if (sif.frame_start) high_sh_q <= high_q;
  end

  assign high_cur        = high_q;
  assign high_diff       = (high_sh_q != high_q);
  assign sif.high_score  = high_sh_q;
  assign sif.new_high    = new_high_q;
`else
  assign high_cur        = '0;
  assign high_diff       = 1'b0;
  assign sif.high_score  = '0;
  assign sif.new_high    = 1'b0;
`endif

  // Shadow score registers load only on frame_start; pulse when anything changed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      score_q   <= '0;
      bcd_q     <= '0;
      updated_q <= 1'b0;
    end else if (sif.frame_start) begin
      score_q   <= live_bin;
      bcd_q     <= live_bcd;
      updated_q <= (score_q != live_bin) || (bcd_q != live_bcd) || high_diff;
    end else begin
      updated_q <= 1'b0;
    end
  end

  assign sif.score         = score_q;
  assign sif.score_bcd     = bcd_q;
  assign sif.score_updated = updated_q;
  assign sif.state         = state_q;

endmodule

// File: tb/tb_score_keeper.sv
// Bench for score_keeper: directed scenarios plus random events against a score model.
module tb_score_keeper;
  import score_pkg::*;

  localparam int unsigned MAXS = 999;

  logic clk;
  logic reset_n;

  score_keeper_if #(.SCORE_W(32), .DIGITS(3)) bus ();

  score_keeper #(.MAX_SCORE(MAXS), .DIGITS(3), .SCORE_W(32)) u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .sif     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int m_st, m_live, m_high, m_sh_score, m_sh_high;
  bit m_new, m_upd;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] to_bcd(input int v);
    return 32'(((v / 100) % 10) * 256 + ((v / 10) % 10) * 16 + (v % 10));
  endfunction

  task automatic model_reset();
    m_st = 0; m_live = 0; m_high = 0; m_sh_score = 0; m_sh_high = 0;
    m_new = 0; m_upd = 0;
  endtask

  task automatic model_step(input bit gs, input bit pe, input bit go, input bit fs);
    m_upd = 0;
    if (fs) begin
      m_upd      = (m_sh_score != m_live) || (m_sh_high != m_high);
      m_sh_score = m_live;
      m_sh_high  = m_high;
    end
    if (gs) begin
      m_live = 0;
      m_st   = 1;
      m_new  = 0;
    end else if (m_st == 1) begin
      if (pe && m_live < int'(MAXS)) m_live++;
      if (go) begin
        m_st = 2;
`ifdef SCORE_HIGH_SCORE_EN
        if (m_live > m_high) begin
          m_high = m_live;
          m_new  = 1;
        end else begin
          m_new = 0;
        end
`endif
      end
    end
  endtask

  task automatic check_all();
    check("state", 32'(bus.state), 32'(m_st));
    check("score", bus.score, 32'(m_sh_score));
    check("score_bcd", 32'(bus.score_bcd), to_bcd(m_sh_score));
    check("high_score", bus.high_score, 32'(m_sh_high));
    check("new_high", 32'(bus.new_high), 32'(m_new));
    check("score_updated", 32'(bus.score_updated), 32'(m_upd));
  endtask

  task automatic cycle(input bit gs, input bit pe, input bit go, input bit fs);
    bus.game_start  = gs;
    bus.point_event = pe;
    bus.game_over   = go;
    bus.frame_start = fs;
    @(posedge clk);
    #1;
    bus.game_start  = 1'b0;
    bus.point_event = 1'b0;
    bus.game_over   = 1'b0;
    bus.frame_start = 1'b0;
    model_step(gs, pe, go, fs);
    check_all();
  endtask

  task automatic points(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic round(input int n);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    points(n);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    bus.game_start  = 1'b0;
    bus.point_event = 1'b0;
    bus.game_over   = 1'b0;
    bus.frame_start = 1'b0;
    reset_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    reset_n = 1'b1;

    // Carry and frame sync
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    points(19);
    check("no_frame_hold", bus.score, 32'd0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    check("carry19_bin", bus.score, 32'd19);
    check("carry19_bcd", 32'(bus.score_bcd), 32'h019);
    check("carry19_pulse", 32'(bus.score_updated), 32'd1);
    points(1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    check("carry20_bcd", 32'(bus.score_bcd), 32'h020);

    // Saturation
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    points(1005);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    check("sat_bin", bus.score, 32'd999);
    check("sat_bcd", 32'(bus.score_bcd), 32'h999);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    check("sat_no_pulse", 32'(bus.score_updated), 32'd0);

    // Asynchronous reset mid-round
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    points(57);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    check("pre_reset_57", bus.score, 32'd57);
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    check("async_rst_score", bus.score, 32'd0);
    check("async_rst_bcd", 32'(bus.score_bcd), 32'd0);
    check("async_rst_state", 32'(bus.state), 32'd0);
    check("async_rst_high", bus.high_score, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Ignored events in IDLE
    points(5);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    check("idle_ignore_state", 32'(bus.state), 32'd0);
    check("idle_ignore_score", bus.score, 32'd0);

    // High score rounds
    round(42);
`ifdef SCORE_HIGH_SCORE_EN
    check("hs_r1", bus.high_score, 32'd42);
    check("hs_r1_new", 32'(bus.new_high), 32'd1);
`else
    check("hs_off_r1", bus.high_score, 32'd0);
`endif
    round(30);
`ifdef SCORE_HIGH_SCORE_EN
    check("hs_r2", bus.high_score, 32'd42);
    check("hs_r2_new", 32'(bus.new_high), 32'd0);
`endif
    // Ignored points in OVER
    points(4);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    check("over_ignore", bus.score, 32'd30);
    round(43);
`ifdef SCORE_HIGH_SCORE_EN
    check("hs_r3", bus.high_score, 32'd43);
    check("hs_r3_new", 32'(bus.new_high), 32'd1);
`else
    check("hs_off_r3", bus.high_score, 32'd0);
    check("hs_off_new", 32'(bus.new_high), 32'd0);
`endif

    // Simultaneous events
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    points(9);
    cycle(1'b0, 1'b1, 1'b1, 1'b0);
    check("go_pe_state", 32'(bus.state), 32'd2);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    check("go_pe_final", bus.score, 32'd10);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    points(3);
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    check("gs_pe_live0", bus.score, 32'd0);
    points(5);
    cycle(1'b0, 1'b1, 1'b0, 1'b1);
    check("fs_pe_pre", bus.score, 32'd5);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    check("fs_pe_post", bus.score, 32'd6);
    cycle(1'b1, 1'b0, 1'b1, 1'b0);
    check("gs_go_state", 32'(bus.state), 32'd1);

    // Random events against the model
    for (int i = 0; i < 4000; i++) begin
      cycle(($urandom_range(0, 63) == 0), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 31) == 0), ($urandom_range(0, 7) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/score_keeper.md
Name: score_keeper

Overview:
- Producer side of the score path: counts point events from game logic and maintains the running score.
- Keeps the score as binary and as packed BCD digits, so the display can index digit glyphs without a divide/subtract chain.
- Presents frame-stable score outputs that change only on frame_start, so a frame never shows a mix of old and new digits.
- Tracks the session high score. Sits between game-logic/collision and the VGA score renderer.

Parameters:
MAX_SCORE, 999, saturation ceiling; must be ≤ 10^DIGITS - 1
DIGITS, 3, number of BCD decades kept
SCORE_W, 32, width of binary score outputs

Ports:
clk  in  1  system clock (pixel-domain clock)
reset_n  in  1  asynchronous active-low reset
game_start  in  1  one-cycle pulse: clear live score, enter PLAYING
point_event  in  1  one-cycle pulse: +1 point
game_over  in  1  one-cycle pulse: end round, commit high score
frame_start  in  1  one-cycle pulse at start of vertical blank; shadow-update strobe
score  out  SCORE_W  frame-stable binary score
score_bcd  out  4*DIGITS  frame-stable BCD; [3:0] ones, [7:4] tens, [11:8] hundreds
high_score  out  SCORE_W  frame-stable high score
new_high  out  1  high if the latest round end produced a new high score
score_updated  out  1  one-cycle pulse: shadow outputs changed this cycle
state  out  2  0 IDLE, 1 PLAYING, 2 OVER

Behaviour:
- Reset (async, reset_n=0):
  - Outputs: all zero, new_high=0, score_updated=0, state=IDLE.
  - Internals: live binary and BCD counters = 0, high-score register = 0.
- State machine:
  - IDLE -> PLAYING on game_start.
  - PLAYING -> OVER on game_over.
  - OVER -> PLAYING on game_start.
  - game_start in PLAYING restarts the round: live score cleared, state stays PLAYING.
  - game_over outside PLAYING is ignored.
- Live counting (registered, 1-cycle latency):
  - point_event in PLAYING increments the live binary and BCD counters.
  - BCD decade carry: a digit at 9 goes to 0 and carries into the next decade.
  - point_event outside PLAYING is ignored.
- Saturation: at MAX_SCORE, further point_events hold the value; binary and BCD stay at 999/0x999, with no wrap to 0.
- Simultaneous events:
  - game_start with point_event: start wins, live = 0.
  - game_over with point_event in PLAYING: the point counts (live+1 used for the high-score compare), then OVER.
  - game_start with game_over: game_start wins.
- Round end (PLAYING -> OVER):
  - If the final live score > high score register: load the register and set new_high=1.
  - Otherwise new_high=0.
  - new_high clears on the next game_start.
- Frame sync:
  - On frame_start, score/score_bcd/high_score load from their internal values on the next clock edge.
  - score_updated pulses in that cycle only if any of the three values differs.
  - Between frame_start pulses the outputs hold, regardless of events.
- frame_start coinciding with point_event: the shadow takes the pre-increment value; the increment appears at the next frame_start.
- Invariant: binary score == decimal value of BCD at all times, for both live and shadow copies.
- state output is not frame-synced; it is the FSM register.

Optional Feature:
SCORE_HIGH_SCORE_EN
- Defined: high-score register, compare logic and new_high as above.
- Undefined:
  - high_score tied to 0 and new_high tied to 0.
  - No high-score register is synthesised.
  - score_updated reflects score/score_bcd changes only.

Decomposition:
- Package score_pkg:
  - state encoding localparams (ST_IDLE=0, ST_PLAYING=1, ST_OVER=2).
  - DIGIT_W=4.
  - default MAX_SCORE/DIGITS constants, shared with the score display.
- Sub-module bcd_digit_counter: one decade.
  - Inputs: clk, reset_n, clr, inc, hold.
  - Outputs: digit[3:0], carry_out (inc && digit==9).
  - Instantiated DIGITS times in a carry chain; hold is driven by the top-level saturation detect.

Test Plan:
- Reset mid-round: score live at 57, assert reset_n=0 asynchronously between edges -> all outputs 0 immediately, state=IDLE, high_score=0.
- Carry and frame sync: game_start, 19 point_events, no frame_start -> score stays 0; after frame_start -> score=19, score_bcd=0x019, one score_updated pulse; one more event plus frame_start -> 20, 0x020.
- Saturation: drive 1005 point_events then frame_start -> score=999, score_bcd=0x999, no wrap; a further frame_start gives no score_updated pulse.
- High score: round 1 ends at 42 -> high_score=42, new_high=1; round 2 ends at 30 -> high_score=42, new_high=0; round 3 ends at 43 -> 43, new_high=1. With SCORE_HIGH_SCORE_EN undefined, high_score stays 0 throughout.
- Simultaneous events:
  - game_over with point_event at live 9 -> final 10, OVER.
  - game_start with point_event -> live 0.
  - frame_start with point_event at live 5 -> shadow 5, then 6 at the next frame.
- Ignored events: point_event in IDLE/OVER and game_over in IDLE -> no change to live score or state.
